// File: rtl/thor2023_wb_scratchpad_pkg.sv
// Shared Wishbone request/response types and cycle-type codes for the Thor2023 128-bit bus.
package thor2023_wb_scratchpad_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
    logic [2:0]   cti;
    logic [1:0]   bte;
    logic [7:0]   blen;
    logic [7:0]   tid;
  } wb_write_request128_t;

  typedef struct packed {
    logic         ack;
    logic         err;
    logic         rty;
    logic [7:0]   tid;
    logic [127:0] dat;
  } wb_read_response128_t;

  // Beats in a transaction: incrementing bursts carry blen+1, everything else is one beat.
  function automatic logic [8:0] wb_beats(input logic [2:0] cti, input logic [7:0] blen);
    return (cti == CTI_INCR) ? ({1'b0, blen} + 9'd1) : 9'd1;
  endfunction

endpackage

// File: rtl/thor2023_wb_scratchpad_if.sv
// Wishbone request/response bundle between the core BIU (master) and a responder (slave).
interface thor2023_wb_scratchpad_if;
  import thor2023_wb_scratchpad_pkg::*;

  wb_write_request128_t wbs_req;
  wb_read_response128_t wbs_resp;

  modport master (output wbs_req, input wbs_resp);
  modport slave  (input wbs_req, output wbs_resp);
endinterface

// File: rtl/thor2023_bram128.sv
// Single-port DEPTH x 128 RAM with per-byte write enables and a registered read port.
module thor2023_bram128 #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_we,
  input  logic [15:0]    i_sel,
  input  logic [AW-1:0]  i_adr,
  input  logic [127:0]   i_dat,
  output logic [127:0]   o_dat
);

  logic [127:0] r_mem [DEPTH];
  logic [127:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 16; b++) begin
        if (i_sel[b]) r_mem[i_adr][b*8 +: 8] <= i_dat[b*8 +: 8];
      end
    end
    r_q <= r_mem[i_adr];
  end

  assign o_dat = r_q;

endmodule

// File: rtl/thor2023_wb_scratchpad.sv
// Wishbone scratchpad responder: single-beat and incrementing-burst access to a byte-enabled RAM,
// with transaction-ID echo and err on addresses outside the window.
module thor2023_wb_scratchpad import thor2023_wb_scratchpad_pkg::*; #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] BASE_ADR = 32'hFFFC_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  thor2023_wb_scratchpad_if.slave wbs
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] LINE_MSK = 32'(DEPTH * 16 - 1);

  typedef enum logic [2:0] {StIdle, StRd, StRdBurst, StWrBurst, StErr, StWaitStb} state_e;

  wb_write_request128_t w_req;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_idx;
  logic [8:0]           w_beats;
  logic                 w_ram_we;
  logic [IDX_W-1:0]     w_ram_adr;
  logic [127:0]         w_rdata;
  logic                 w_unused;

  state_e           r_state;
  logic             r_ack;
  logic             r_err;
  logic [7:0]       r_tid;
  logic [127:0]     r_dat;
  logic [IDX_W-1:0] r_idx;
  logic [8:0]       r_cnt;
  logic [8:0]       r_beats;

  assign w_req    = wbs.wbs_req;
  assign w_hit    = (w_req.adr & ~LINE_MSK) == BASE_ADR;
  assign w_idx    = w_req.adr[IDX_W+3:4];
  assign w_beats  = wb_beats(w_req.cti, w_req.blen);
  assign w_unused = ^{w_req.bte, w_req.adr[3:0]};

  // r_idx names the line the RAM presents (reads) or the next line to write (write bursts).
  always_comb begin
    w_ram_we  = 1'b0;
    w_ram_adr = w_idx;
    unique case (r_state)
      StIdle:    w_ram_we = w_req.cyc & w_req.stb & w_hit & w_req.we;
      StRd:      w_ram_adr = r_idx + IDX_W'(1);
      StRdBurst: w_ram_adr = w_req.stb ? r_idx + IDX_W'(1) : r_idx;
      StWrBurst: begin
        w_ram_adr = r_idx;
        w_ram_we  = w_req.cyc & w_req.stb;
      end
      default: ;
    endcase
    if (rst_i) w_ram_we = 1'b0;
  end

  thor2023_bram128 #(.DEPTH(DEPTH)) u_ram (
    .i_clk (clk_i),
    .i_we  (w_ram_we),
    .i_sel (w_req.sel),
    .i_adr (w_ram_adr),
    .i_dat (w_req.dat),
    .o_dat (w_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_tid   <= '0;
      r_dat   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_beats <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
      if (!w_req.cyc) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_req.stb) begin
              r_tid   <= w_req.tid;
              r_beats <= w_beats;
              r_cnt   <= 9'd1;
              if (!w_hit) begin
                r_err   <= 1'b1;
                r_state <= StErr;
              end else if (w_req.we) begin
                r_ack   <= 1'b1;
                r_idx   <= w_idx + IDX_W'(1);
                r_state <= (w_beats == 9'd1) ? StWaitStb : StWrBurst;
              end else begin
                r_idx   <= w_idx;
                r_state <= StRd;
              end
            end
          end
          StRd: begin
            r_ack   <= 1'b1;
            r_dat   <= w_rdata;
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= (r_beats == 9'd1) ? StWaitStb : StRdBurst;
          end
          StRdBurst: begin
            if (w_req.stb) begin
              r_ack <= 1'b1;
              r_dat <= w_rdata;
              r_idx <= r_idx + IDX_W'(1);
              r_cnt <= r_cnt + 9'd1;
              if ((r_cnt + 9'd1 == r_beats) || (w_req.cti == CTI_EOB)) r_state <= StWaitStb;
            end
          end
          StWrBurst: begin
            if (w_req.stb) begin
              r_ack <= 1'b1;
              r_idx <= r_idx + IDX_W'(1);
              r_cnt <= r_cnt + 9'd1;
              if ((r_cnt + 9'd1 == r_beats) || (w_req.cti == CTI_EOB)) r_state <= StWaitStb;
            end
          end
          StErr:     r_state <= StWaitStb;
          StWaitStb: if (!w_req.stb) r_state <= StIdle;
          default:   r_state <= StIdle;
        endcase
      end
    end
  end

  assign wbs.wbs_resp = '{ack: r_ack, err: r_err, rty: 1'b0, tid: r_tid, dat: r_dat};

endmodule

// File: tb/tb_thor2023_wb_scratchpad.sv
// Self-checking bench for thor2023_wb_scratchpad: random traffic against a line-array memory model.
module tb_thor2023_wb_scratchpad;
  import thor2023_wb_scratchpad_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'hFFFC_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thor2023_wb_scratchpad_if bus ();

  thor2023_wb_scratchpad #(.DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wbs   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] m_mem [DEPTH];
  logic [127:0] g_wdat[$];
  logic [127:0] g_rdat[$];
  logic [7:0]   g_tid[$];
  int           g_ack_cyc[$];
  int           g_err_cyc[$];
  logic [127:0] g_err_dat[$];
  logic [7:0]   g_err_tid[$];

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Low nibble is random: the responder must ignore it.
  function automatic logic [31:0] adr_of(input int line);
    return BASE + 32'(line * 16) + 32'($urandom_range(0, 15));
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                         input logic [15:0] sel);
    logic [127:0] m;
    for (int b = 0; b < 16; b++) m[b*8 +: 8] = sel[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return m;
  endfunction

  task automatic model_write(input int line, input int beats, input logic [15:0] sel);
    for (int n = 0; n < beats; n++)
      m_mem[(line + n) % DEPTH] = merge(m_mem[(line + n) % DEPTH], g_wdat[n], sel);
  endtask

  task automatic drive_idle();
    bus.wbs_req = '0;
  endtask

  task automatic sample(input int cyc);
    if (bus.wbs_resp.ack === 1'b1) begin
      g_ack_cyc.push_back(cyc);
      g_rdat.push_back(bus.wbs_resp.dat);
      g_tid.push_back(bus.wbs_resp.tid);
    end
    if (bus.wbs_resp.err === 1'b1) begin
      g_err_cyc.push_back(cyc);
      g_err_dat.push_back(bus.wbs_resp.dat);
      g_err_tid.push_back(bus.wbs_resp.tid);
    end
  endtask

  // Cycle numbering: the request is sampled at the edge closing cycle 0, so cycle 1 is N+1.
  task automatic run_txn(input bit we, input logic [31:0] adr, input logic [2:0] cti,
                         input logic [7:0] blen, input logic [7:0] tid, input logic [15:0] sel,
                         input int stall_at, input int stall_len);
    int beats;
    int consumed;
    int c;
    bit stb;
    bit done;
    beats = (cti == CTI_INCR) ? int'(blen) + 1 : 1;
    consumed = 0;
    c = 0;
    done = 0;
    g_rdat.delete(); g_tid.delete(); g_ack_cyc.delete();
    g_err_cyc.delete(); g_err_dat.delete(); g_err_tid.delete();
    while (!done && c < 200) begin
      stb = !(c >= stall_at && c < stall_at + stall_len);
      bus.wbs_req.cyc  = 1'b1;
      bus.wbs_req.stb  = stb;
      bus.wbs_req.we   = we;
      bus.wbs_req.sel  = sel;
      bus.wbs_req.adr  = adr;
      bus.wbs_req.cti  = cti;
      bus.wbs_req.bte  = 2'b00;
      bus.wbs_req.blen = blen;
      bus.wbs_req.tid  = tid;
      bus.wbs_req.dat  = we ? g_wdat[(consumed < beats) ? consumed : beats - 1] : '0;
      @(posedge clk); #1;
      if (we && stb) consumed++;
      sample(c + 1);
      c++;
      if (g_err_cyc.size() > 0) done = 1;
      if (we && consumed >= beats) done = 1;
      if (!we && g_ack_cyc.size() >= beats) done = 1;
    end
    drive_idle();
    repeat (3) begin
      @(posedge clk); #1;
      sample(c + 1);
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.wbs_resp.ack !== 1'b0) $display("FAIL reset_ack got %b want 0", bus.wbs_resp.ack); else n_pass++;
    n_checks++; if (bus.wbs_resp.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.wbs_resp.err); else n_pass++;
    n_checks++; if (bus.wbs_resp.rty !== 1'b0) $display("FAIL reset_rty got %b want 0", bus.wbs_resp.rty); else n_pass++;
    n_checks++; if (bus.wbs_resp.tid !== 8'h00) $display("FAIL reset_tid got %h want 00", bus.wbs_resp.tid); else n_pass++;
    n_checks++; if (bus.wbs_resp.dat !== 128'h0) $display("FAIL reset_dat got %h want 0", bus.wbs_resp.dat); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    g_wdat.delete();
    for (int i = 0; i < DEPTH; i++) g_wdat.push_back(rnd128());
    run_txn(1'b1, adr_of(0), CTI_INCR, 8'(DEPTH - 1), 8'h11, 16'hFFFF, 1000, 0);
    model_write(0, DEPTH, 16'hFFFF);
    n_checks++;
    if (g_ack_cyc.size() != DEPTH) $display("FAIL fill_acks got %0d want %0d", g_ack_cyc.size(), DEPTH);
    else n_pass++;
    for (int i = 0; i < DEPTH && i < g_ack_cyc.size(); i++) begin
      n_checks++;
      if (g_ack_cyc[i] != i + 1 || g_tid[i] !== 8'h11 || g_rdat[i] !== 128'h0)
        $display("FAIL fill_beat%0d got cyc=%0d tid=%h dat=%h want cyc=%0d tid=11 dat=0",
                 i, g_ack_cyc[i], g_tid[i], g_rdat[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_single_write_read();
    logic [127:0] d;
    d = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    g_wdat = '{d};
    run_txn(1'b1, BASE + 32'h20, CTI_CLASSIC, 8'd0, 8'd5, 16'hFFFF, 1000, 0);
    model_write(2, 1, 16'hFFFF);
    n_checks++;
    if (g_ack_cyc.size() != 1 || g_ack_cyc[0] != 1 || g_tid[0] !== 8'd5 || g_rdat[0] !== 128'h0)
      $display("FAIL single_write_ack got n=%0d cyc=%0d tid=%h want n=1 cyc=1 tid=05",
               g_ack_cyc.size(), (g_ack_cyc.size() > 0) ? g_ack_cyc[0] : -1,
               (g_tid.size() > 0) ? g_tid[0] : 8'hxx);
    else n_pass++;
    run_txn(1'b0, BASE + 32'h20, CTI_CLASSIC, 8'd0, 8'd6, 16'hFFFF, 1000, 0);
    n_checks++;
    if (g_ack_cyc.size() != 1 || g_ack_cyc[0] != 2 || g_tid[0] !== 8'd6)
      $display("FAIL single_read_ack got n=%0d cyc=%0d want n=1 cyc=2 tid=06",
               g_ack_cyc.size(), (g_ack_cyc.size() > 0) ? g_ack_cyc[0] : -1);
    else n_pass++;
    n_checks++;
    if (g_rdat.size() < 1 || g_rdat[0] !== d)
      $display("FAIL single_read_data got %h want %h", (g_rdat.size() > 0) ? g_rdat[0] : 'x, d);
    else n_pass++;
  endtask

  task automatic test_partial_write();
    g_wdat = '{'1};
    run_txn(1'b1, adr_of(5), CTI_CLASSIC, 8'd0, 8'h20, 16'hFFFF, 1000, 0);
    model_write(5, 1, 16'hFFFF);
    g_wdat = '{128'hDEADBEEF};
    run_txn(1'b1, adr_of(5), CTI_CLASSIC, 8'd0, 8'h21, 16'h000F, 1000, 0);
    model_write(5, 1, 16'h000F);
    run_txn(1'b0, adr_of(5), CTI_CLASSIC, 8'd0, 8'h22, 16'hFFFF, 1000, 0);
    n_checks++;
    if (g_rdat.size() != 1 || g_rdat[0] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF)
      $display("FAIL partial_write got %h want FFFFFFFFFFFFFFFFFFFFFFFFDEADBEEF",
               (g_rdat.size() > 0) ? g_rdat[0] : 'x);
    else n_pass++;
  endtask

  task automatic test_read_burst_wrap();
    run_txn(1'b0, adr_of(DEPTH - 2), CTI_INCR, 8'd3, 8'h44, 16'hFFFF, 1000, 0);
    n_checks++;
    if (g_ack_cyc.size() != 4) $display("FAIL wrap_acks got %0d want 4", g_ack_cyc.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < g_ack_cyc.size(); i++) begin
      n_checks++;
      if (g_ack_cyc[i] != i + 2 || g_tid[i] !== 8'h44 || g_rdat[i] !== m_mem[(DEPTH - 2 + i) % DEPTH])
        $display("FAIL wrap_beat%0d got cyc=%0d dat=%h want cyc=%0d dat=%h", i, g_ack_cyc[i],
                 g_rdat[i], i + 2, m_mem[(DEPTH - 2 + i) % DEPTH]);
      else n_pass++;
    end
  endtask

  task automatic test_write_burst_stall();
    int exp_cyc[$];
    int c;
    g_wdat.delete();
    for (int i = 0; i < 8; i++) g_wdat.push_back(rnd128());
    c = 0;
    while (exp_cyc.size() < 8) begin
      if (!(c >= 3 && c < 5)) exp_cyc.push_back(c + 1);
      c++;
    end
    run_txn(1'b1, adr_of(4), CTI_INCR, 8'd7, 8'h57, 16'hFFFF, 3, 2);
    model_write(4, 8, 16'hFFFF);
    n_checks++;
    if (g_ack_cyc.size() != 8) $display("FAIL wrstall_acks got %0d want 8", g_ack_cyc.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < g_ack_cyc.size(); i++) begin
      n_checks++;
      if (g_ack_cyc[i] != exp_cyc[i])
        $display("FAIL wrstall_cyc%0d got %0d want %0d", i, g_ack_cyc[i], exp_cyc[i]);
      else n_pass++;
    end
    run_txn(1'b0, adr_of(4), CTI_INCR, 8'd7, 8'h58, 16'hFFFF, 1000, 0);
    for (int i = 0; i < 8 && i < g_rdat.size(); i++) begin
      n_checks++;
      if (g_rdat[i] !== m_mem[4 + i])
        $display("FAIL wrstall_line%0d got %h want %h", 4 + i, g_rdat[i], m_mem[4 + i]);
      else n_pass++;
    end
  endtask

  task automatic test_error();
    g_wdat = '{rnd128()};
    run_txn(1'b1, BASE - 32'd16, CTI_CLASSIC, 8'd0, 8'h3C, 16'hFFFF, 1000, 0);
    n_checks++;
    if (g_err_cyc.size() != 1 || g_err_cyc[0] != 1 || g_err_tid[0] !== 8'h3C || g_err_dat[0] !== '0)
      $display("FAIL err_write got n=%0d cyc=%0d tid=%h want n=1 cyc=1 tid=3c dat=0",
               g_err_cyc.size(), (g_err_cyc.size() > 0) ? g_err_cyc[0] : -1,
               (g_err_tid.size() > 0) ? g_err_tid[0] : 8'hxx);
    else n_pass++;
    n_checks++;
    if (g_ack_cyc.size() != 0) $display("FAIL err_write_ack got %0d acks want 0", g_ack_cyc.size());
    else n_pass++;
    run_txn(1'b0, BASE - 32'd16, CTI_INCR, 8'd2, 8'h3D, 16'hFFFF, 1000, 0);
    n_checks++;
    if (g_err_cyc.size() != 1 || g_err_cyc[0] != 1 || g_ack_cyc.size() != 0 || g_err_tid[0] !== 8'h3D)
      $display("FAIL err_read got errs=%0d acks=%0d want errs=1 acks=0", g_err_cyc.size(),
               g_ack_cyc.size());
    else n_pass++;
    run_txn(1'b0, adr_of(DEPTH - 1), CTI_CLASSIC, 8'd0, 8'h3E, 16'hFFFF, 1000, 0);
    n_checks++;
    if (g_rdat.size() != 1 || g_rdat[0] !== m_mem[DEPTH - 1])
      $display("FAIL err_ram_unchanged got %h want %h", (g_rdat.size() > 0) ? g_rdat[0] : 'x,
               m_mem[DEPTH - 1]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      bit we;
      bit burst;
      int line, beats, stall_at, stall_len, c;
      logic [7:0] blen, tid;
      logic [15:0] sel;
      int exp_cyc[$];
      we = 1'($urandom_range(0, 1));
      burst = 1'($urandom_range(0, 1));
      line = $urandom_range(0, DEPTH - 1);
      blen = burst ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      beats = burst ? int'(blen) + 1 : 1;
      sel = 16'($urandom);
      tid = 8'($urandom);
      stall_at = we ? $urandom_range(0, 4) : $urandom_range(2, 5);
      stall_len = $urandom_range(0, 2);
      if (we) c = 0;
      else begin
        exp_cyc.push_back(2);
        c = 2;
      end
      while (exp_cyc.size() < beats) begin
        if (!(c >= stall_at && c < stall_at + stall_len)) exp_cyc.push_back(c + 1);
        c++;
      end
      g_wdat.delete();
      for (int i = 0; i < beats; i++) g_wdat.push_back(rnd128());
      run_txn(we, adr_of(line), burst ? CTI_INCR : CTI_CLASSIC, blen, tid, sel, stall_at, stall_len);
      n_checks++;
      if (g_ack_cyc.size() != beats || g_err_cyc.size() != 0)
        $display("FAIL rand%0d_count got acks=%0d errs=%0d want acks=%0d errs=0", it,
                 g_ack_cyc.size(), g_err_cyc.size(), beats);
      else n_pass++;
      for (int i = 0; i < beats && i < g_ack_cyc.size(); i++) begin
        logic [127:0] want;
        want = we ? 128'h0 : m_mem[(line + i) % DEPTH];
        n_checks++;
        if (g_ack_cyc[i] != exp_cyc[i] || g_tid[i] !== tid || g_rdat[i] !== want)
          $display("FAIL rand%0d_beat%0d got cyc=%0d tid=%h dat=%h want cyc=%0d tid=%h dat=%h",
                   it, i, g_ack_cyc[i], g_tid[i], g_rdat[i], exp_cyc[i], tid, want);
        else n_pass++;
      end
      if (we) model_write(line, beats, sel);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [127:0] w [8];
    for (int i = 0; i < 8; i++) w[i] = rnd128();
    bus.wbs_req.cyc  = 1'b1;
    bus.wbs_req.stb  = 1'b1;
    bus.wbs_req.we   = 1'b1;
    bus.wbs_req.sel  = 16'hFFFF;
    bus.wbs_req.adr  = adr_of(8);
    bus.wbs_req.cti  = CTI_INCR;
    bus.wbs_req.bte  = 2'b00;
    bus.wbs_req.blen = 8'd7;
    bus.wbs_req.tid  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      bus.wbs_req.dat = w[i];
      if (i == 2) rst = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.wbs_resp.ack !== 1'b0 || bus.wbs_resp.err !== 1'b0 || bus.wbs_resp.rty !== 1'b0 ||
        bus.wbs_resp.tid !== 8'h00 || bus.wbs_resp.dat !== 128'h0)
      $display("FAIL midrst_outputs got ack=%b err=%b rty=%b tid=%h dat=%h want all 0",
               bus.wbs_resp.ack, bus.wbs_resp.err, bus.wbs_resp.rty, bus.wbs_resp.tid,
               bus.wbs_resp.dat);
    else n_pass++;
    rst = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    n_checks++;
    if (bus.wbs_resp.ack !== 1'b0) $display("FAIL midrst_after_ack got %b want 0", bus.wbs_resp.ack);
    else n_pass++;
    m_mem[8] = w[0];
    m_mem[9] = w[1];
    run_txn(1'b0, adr_of(8), CTI_INCR, 8'd7, 8'h9A, 16'hFFFF, 1000, 0);
    n_checks++;
    if (g_rdat.size() != 8) $display("FAIL midrst_readback_n got %0d want 8", g_rdat.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < g_rdat.size(); i++) begin
      n_checks++;
      if (g_rdat[i] !== m_mem[8 + i])
        $display("FAIL midrst_line%0d got %h want %h", 8 + i, g_rdat[i], m_mem[8 + i]);
      else n_pass++;
    end
  endtask

  task automatic test_readback_all();
    run_txn(1'b0, adr_of(3), CTI_INCR, 8'(DEPTH - 1), 8'hA5, 16'hFFFF, 4, 2);
    n_checks++;
    if (g_rdat.size() != DEPTH) $display("FAIL final_n got %0d want %0d", g_rdat.size(), DEPTH);
    else n_pass++;
    for (int i = 0; i < DEPTH && i < g_rdat.size(); i++) begin
      n_checks++;
      if (g_rdat[i] !== m_mem[(3 + i) % DEPTH])
        $display("FAIL final_line%0d got %h want %h", (3 + i) % DEPTH, g_rdat[i],
                 m_mem[(3 + i) % DEPTH]);
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive_idle();
    test_reset();
    test_fill();
    test_single_write_read();
    test_partial_write();
    test_read_burst_wrap();
    test_write_burst_stall();
    test_error();
    test_random();
    test_reset_mid_burst();
    test_readback_all();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/thor2023_wb_scratchpad.md
# thor2023_wb_scratchpad

Wishbone responder (slave) for the Thor2023 128-bit bus: a byte-enabled on-chip scratchpad RAM that answers the core BIU's `wbm_req` with `wbm_resp`. It serves classic single-beat cycles and incrementing bursts, echoes transaction IDs, and flags out-of-range addresses with `err`. It sits on the system bus beside the boot ROM and is the other end of the core's master interface.

## Interface
- `DEPTH`, 1024: number of 128-bit lines; must be a power of two (16 KiB by default).
- `BASE_ADR`, 32'hFFFC0000: byte base address; aligned to DEPTH*16.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `wbs_req`  in  `wb_write_request128_t`  request fields used: cyc, stb, we, sel[15:0], adr, dat[127:0], cti[2:0], bte, blen[7:0], tid.
- `wbs_resp`  out  `wb_read_response128_t`  response fields driven: ack, err, rty, tid, dat[127:0].

## Operation
- Decode:
  - Hit when `(adr & ~(DEPTH*16-1)) == BASE_ADR`.
  - Line index = `adr[$clog2(DEPTH)+3:4]`; `adr[3:0]` is ignored (`sel` selects bytes).
- `rty` is tied 0.
- FSM states: IDLE, RD, RDBURST, WRBURST, ERR, WAITSTB.
- IDLE:
  - Stays in IDLE until `cyc & stb`, then captures `tid`, index, `we`, and `beats = (cti==INCR) ? blen+1 : 1`.
  - Miss: go to ERR.
  - Write hit: write the beat with `sel` byte enables in the same cycle. Go to WRBURST, or to WAITSTB when beats==1.
  - Read hit: issue the RAM read and go to RD.
- RD: the RAM data is valid in this cycle. Assert `ack` with `dat` for one cycle, then:
  - beats==1: go to WAITSTB.
  - otherwise: go to RDBURST.
- RDBURST:
  - Index increments each cycle and wraps modulo DEPTH.
  - One `ack` beat per cycle while `stb` is high.
  - `stb` low: hold the beat and assert no `ack`.
  - After the final beat, or when the master presents `cti==EOB`, go to WAITSTB.
- WRBURST:
  - Each cycle with `stb` high: write `dat`/`sel` at index+n, then pulse `ack`.
  - Done when n reaches `beats` or on `cti==EOB`; then go to WAITSTB.
- ERR: pulse `err` for one cycle with `tid` echoed and `dat`=0; no RAM access. Go to WAITSTB.
- WAITSTB: return to IDLE when `stb==0` or `cyc==0`. This prevents re-accepting a held request.
- `cyc` low in any state: return to IDLE next cycle. No further RAM writes and no more `ack`.
- `tid` is echoed on every `ack`/`err`.
- `dat` is 0 on write acks and while no ack is asserted.

## Timing
- Reset values:
  - `ack=0`, `err=0`, `rty=0`, `tid=0`, `dat=0`.
  - State is IDLE.
  - RAM contents are not cleared.
- Reset mid-burst: abort immediately. Any write in the reset cycle is suppressed.
- Single read: request sampled at edge N; `ack` and data valid in cycle N+2 (registered RAM). RAM latency is one cycle.
- Single write: RAM is written at edge N+1; `ack` valid in cycle N+1.
- Read burst of B beats: acks in cycles N+2 … N+B+1 when `stb` is held; one beat per clock after the first.
- Write burst: first ack in cycle N+1, then one per cycle.
- Error: `err` in cycle N+1.
- `ack` and `err` are never asserted in the same cycle.
- Read-after-write to the same line in back-to-back transactions returns the new data.
- Wrap-around: index DEPTH-1 is followed by 0 inside a burst.

## Structure
- `Thor2023Pkg` already holds the WB request/response types.
- Add `CTI_CLASSIC=3'b000`, `CTI_INCR=3'b010`, `CTI_EOB=3'b111` there if absent.
- The FSM state enum is local to this module.
- One sub-module: `thor2023_bram128`, a single-port DEPTH×128 RAM.
  - 16 byte-write enables.
  - Registered read output (1-cycle latency).
  - Inferable as block RAM.

## Test plan
- Write 128'h0011…EEFF, `sel`=16'hFFFF, to BASE+0x20, tid=5. Then read it back with tid=6. Expect a write ack at N+1 with tid=5, a read ack at N+2 with the same data, and tid=6.
- Partial write: `sel`=16'h000F, dat=32'hDEADBEEF, over a line of all 1s. Read returns 128'hFFFF…FFFF_DEADBEEF.
- Read burst, `cti`=INCR, blen=3, starting at line DEPTH-2. Expect 4 consecutive acks with data from lines DEPTH-2, DEPTH-1, 0, 1.
- Write burst, blen=7, with `stb` low for 2 cycles mid-burst. Expect exactly 8 acks and 8 lines written, with no ack during the stall.
- Access BASE-16. Expect a one-cycle `err` at N+1 with tid echoed, no `ack`, and RAM unchanged.
- Assert `rst_i` during the 3rd beat of a write burst. All outputs are 0 next cycle, beats 3+ are not written, and beats 1–2 keep their data.
